// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// State and error encodings live here so the loader and its users agree on them.
package imem_load_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_RECV   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_VERIFY = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_RANGE   = 2'd1,
      ERR_VERIFY  = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Misaligned base, or last word past the end of imem; the sum is wide enough never to wrap.
   function automatic logic range_bad(input logic [31:0] base,
                                      input logic [15:0] count,
                                      input logic [30:0] limit);
      logic [30:0] end_word;
      end_word = {1'b0, base[31:2]} + {15'd0, count};
      return (base[1:0] != 2'b00) || (end_word > limit);
   endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid marks the 4th byte.
module imem_byte_packer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  idx_q;
   logic [31:0] word_q;

   // Shifting in from the top leaves the first byte in [7:0] after four accepts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (clear) begin
         idx_q  <= '0;
      end else if (accept) begin
         idx_q  <= idx_q + 2'd1;
         word_q <= {byte_data, word_q[31:8]};
      end
   end

   assign word       = word_q;
   assign word_valid = accept && (idx_q == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Program loader: packs streamed bytes into words, writes them through the imem
// debug port, optionally reads each back, and holds the core for the whole load.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter bit          VERIFY_EN   = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] base_addr,
   input  logic [15:0] word_count,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        dbg_en,
   output logic [31:0] dbg_addr,
   output logic [31:0] dbg_wdata,
   output logic        dbg_we,
   input  logic [31:0] dbg_rdata,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] words_loaded
);

   localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

   state_t      state_q, state_d;
   err_t        err_q, err_d;
   logic [31:0] base_q, addr_q;
   logic [15:0] count_q, loaded_q, idle_q;
   logic        is_busy, accept, take_start, advance, load_addr;
   logic        word_valid;
   logic [31:0] word;

   assign is_busy    = state_q inside {ST_CHECK, ST_RECV, ST_WRITE, ST_VERIFY};
   assign accept     = byte_valid && (state_q == ST_RECV);
   assign take_start = start && !is_busy;

   imem_byte_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (take_start),
      .accept     (accept),
      .byte_data  (byte_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      advance   = 1'b0;
      load_addr = 1'b0;
      unique case (state_q)
         ST_CHECK: begin
            if (range_bad(base_q, count_q, MEM_LIMIT)) begin
               state_d = ST_ERROR;
               err_d   = ERR_RANGE;
            end else if (count_q == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d   = ST_RECV;
               load_addr = 1'b1;
            end
         end
         ST_RECV: begin
            if (word_valid) begin
               state_d = ST_WRITE;
            end else if (!accept && (idle_q == IDLE_LAST)) begin
               state_d = ST_ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         ST_WRITE: begin
            if (VERIFY_EN) state_d = ST_VERIFY;
            else           advance = 1'b1;
         end
         ST_VERIFY: begin
            if (dbg_rdata != word) begin
               state_d = ST_ERROR;
               err_d   = ERR_VERIFY;
            end else begin
               advance = 1'b1;
            end
         end
         default: ;
      endcase

      if (advance) state_d = (16'(loaded_q + 16'd1) == count_q) ? ST_DONE : ST_RECV;

      // Abort outranks everything while busy; once idle/finished, start outranks abort.
      if (is_busy && abort) begin
         state_d   = ST_ERROR;
         err_d     = ERR_TIMEOUT;
         advance   = 1'b0;
         load_addr = 1'b0;
      end else if (take_start) begin
         state_d = ST_CHECK;
         err_d   = ERR_NONE;
      end else if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_ERROR;
         err_d   = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q    <= ERR_NONE;
         base_q   <= '0;
         addr_q   <= '0;
         count_q  <= '0;
         loaded_q <= '0;
         idle_q   <= '0;
      end else begin
         err_q <= err_d;
         if ((state_q != ST_RECV) || accept) idle_q <= '0;
         else                                idle_q <= idle_q + 16'd1;
         if (take_start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            loaded_q <= '0;
         end
         if (load_addr) addr_q <= base_q;
         if (advance) begin
            loaded_q <= loaded_q + 16'd1;
            addr_q   <= addr_q + 32'd4;
         end
      end
   end

   assign byte_ready   = (state_q == ST_RECV);
   assign dbg_en       = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
   assign dbg_we       = (state_q == ST_WRITE);
   assign dbg_wdata    = (state_q == ST_WRITE) ? word : '0;
   assign dbg_addr     = addr_q;
   assign core_hold    = is_busy;
   assign busy         = is_busy;
   assign done         = (state_q == ST_DONE);
   assign error        = (state_q == ST_ERROR);
   assign err_code     = err_q;
   assign words_loaded = loaded_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural imem on the debug port.
module tb_imem_load_ctrl;
   import imem_load_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, start, abort, byte_valid;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic [7:0]  byte_data;
   logic        byte_ready, dbg_en, dbg_we, core_hold, busy, done, error;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [1:0]  err_code;
   logic [15:0] words_loaded;

   logic [31:0] mem [0:1023];
   logic        corrupt_en;
   logic [31:0] corrupt_addr;
   int unsigned we_pulses, ready_cycles;
   int unsigned n_tests, n_fail;
   int unsigned snap;

   imem_load_ctrl #(.MEM_WORDS(1024), .VERIFY_EN(1'b1), .TIMEOUT_CYC(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .base_addr    (base_addr),
      .word_count   (word_count),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_ready   (byte_ready),
      .dbg_en       (dbg_en),
      .dbg_addr     (dbg_addr),
      .dbg_wdata    (dbg_wdata),
      .dbg_we       (dbg_we),
      .dbg_rdata    (dbg_rdata),
      .core_hold    (core_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .err_code     (err_code),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   assign dbg_rdata = mem[dbg_addr[11:2]] ^
      ((corrupt_en && dbg_en && !dbg_we && dbg_addr == corrupt_addr) ? 32'h1 : 32'h0);

   always @(posedge clk) begin
      if (dbg_en && dbg_we) mem[dbg_addr[11:2]] <= dbg_wdata;
      if (dbg_we) we_pulses++;
      if (byte_ready) ready_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
      @(negedge clk);
      base_addr = base; word_count = cnt; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      byte_valid = 1'b1; byte_data = b;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8]);
   endtask

   task automatic wait_end(input string tag);
      int unsigned n = 0;
      while (!(done || error) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, done || error}, 32'd1);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; we_pulses = 0; ready_cycles = 0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      corrupt_en = 1'b0; corrupt_addr = '0;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
      byte_data = '0; base_addr = '0; word_count = '0;
      repeat (2) @(negedge clk);
      check("rst_flags", {byte_ready, dbg_en, dbg_we, core_hold, busy, done, error}, 32'd0);
      check("rst_addr", dbg_addr, 32'd0);
      check("rst_wdata", dbg_wdata, 32'd0);
      check("rst_cnt", {14'd0, err_code, words_loaded}, 32'd0);
      reset_n = 1'b1;

      // Basic two-word load with verify
      do_start(32'h100, 16'd2);
      check("t1_hold_check", {31'd0, core_hold}, 32'd1);
      send_word(32'h0000_0013);
      check("t1_we", {30'd0, dbg_en, dbg_we}, 32'd3);
      check("t1_wdata", dbg_wdata, 32'h0000_0013);
      check("t1_addr0", dbg_addr, 32'h100);
      @(negedge clk);
      check("t1_verify", {30'd0, dbg_en, dbg_we}, 32'd2);
      send_word(32'h0010_0093);
      check("t1_addr1", dbg_addr, 32'h104);
      @(negedge clk);
      check("t1_hold_v2", {31'd0, core_hold}, 32'd1);
      @(negedge clk);
      check("t1_hold_fell", {31'd0, core_hold}, 32'd0);
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_loaded", {16'd0, words_loaded}, 32'd2);
      check("t1_mem40", mem[10'h40], NOP_INSTR);
      check("t1_mem41", mem[10'h41], 32'h0010_0093);

      // Range/alignment errors
      snap = we_pulses;
      do_start(32'h102, 16'd1);
      @(negedge clk);
      check("t2_align_err", {29'd0, error, err_code}, 32'h5);
      check("t2_no_we", we_pulses, snap);
      do_start(32'hFFC, 16'd2);
      @(negedge clk);
      check("t2_range_err", {29'd0, error, err_code}, 32'h5);
      do_start(32'hFFC, 16'd1);
      @(negedge clk);
      check("t2_range_edge_ok", {30'd0, byte_ready, error}, 32'h2);

      // Abort mid-RECV after one byte, start asserted alongside
      send_byte(8'h55);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check("t5_abort", {29'd0, error, err_code}, 32'h7);
      check("t5_abort_hold", {31'd0, core_hold}, 32'd0);

      // Zero-length load
      snap = ready_cycles;
      do_start(32'h200, 16'd0);
      check("t3_check_cyc", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("t3_done", {30'd0, done, error}, 32'h2);
      check("t3_no_ready", ready_cycles, snap);

      // Verify mismatch on second word
      corrupt_en = 1'b1; corrupt_addr = 32'h304;
      do_start(32'h300, 16'd3);
      send_word(32'h1122_3344);
      send_word(32'hA5A5_0F0F);
      @(negedge clk);
      @(negedge clk);
      corrupt_en = 1'b0;
      check("t4_err", {29'd0, error, err_code}, 32'h6);
      check("t4_loaded", {16'd0, words_loaded}, 32'd1);
      check("t4_addr", dbg_addr, 32'h304);

      // Idle timeout after two bytes (TIMEOUT_CYC = 8)
      do_start(32'h400, 16'd1);
      send_byte(8'h01);
      send_byte(8'h02);
      repeat (7) @(negedge clk);
      check("t5_to_7idle", {30'd0, busy, error}, 32'h2);
      @(negedge clk);
      check("t5_to_8idle", {29'd0, error, err_code}, 32'h7);

      // Reset mid-WRITE, then a clean reload
      do_start(32'h500, 16'd1);
      send_word(32'hDEAD_BEEF);
      check("t6_in_write", {31'd0, dbg_we}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_flags", {byte_ready, dbg_en, dbg_we, core_hold, busy, done, error}, 32'd0);
      check("t6_async_addr", dbg_addr, 32'd0);
      check("t6_async_wdata", dbg_wdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      do_start(32'h500, 16'd1);
      send_word(32'hAABB_CCDD);
      wait_end("t6_reload_end");
      check("t6_reload_done", {29'd0, done, err_code}, 32'h4);
      check("t6_mem", mem[10'h140], 32'hAABB_CCDD);
      check("t6_loaded", {16'd0, words_loaded}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
